// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts spikes per channel over fixed windows of enabled
// cycles, snapshots the counts at each window end and streams them out one
// channel per valid/ready transfer.
module spike_rate_decoder #(
  parameter int N_CH    = 8,
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_CH-1:0]         spike_in,
  output logic                    rate_valid,
  input  logic                    rate_ready,
  output logic [$clog2(N_CH)-1:0] rate_ch,
  output logic [CNT_W-1:0]        rate_val,
  output logic                    rate_last,
  output logic                    win_done,
  output logic                    overrun
);

  localparam int PTR_W = $clog2(N_CH);
  localparam int TMR_W = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CH - 1);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [TMR_W-1:0] timer_reg;
  logic             overrun_reg, overrun_next;
  logic             win_done_reg;
  logic             load_snap;
  logic             win_end;

  // Saturating count including this cycle's spike, and the held snapshot.
  logic [CNT_W-1:0] cnt_sum  [N_CH];
  logic [CNT_W-1:0] snap_val [N_CH];

  assign win_end  = en && (timer_reg == TMR_LAST);
  assign win_done = win_done_reg;
  assign overrun  = overrun_reg;

  // Window timer: advances only on enabled cycles, wraps at the window end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_reg <= '0;
    end else if (en) begin
      timer_reg <= (timer_reg == TMR_LAST) ? '0 : timer_reg + TMR_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] snap_reg;

      assign cnt_sum[gi]  = (spike_in[gi] && (cnt_reg != CNT_MAX)) ? cnt_reg + CNT_W'(1) : cnt_reg;
      assign snap_val[gi] = snap_reg;

      // Per-channel counter; the end-of-window spike goes into the snapshot,
      // so the counter restarts from zero for the next window.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (en) begin
          cnt_reg <= win_end ? '0 : cnt_sum[gi];
        end
      end

      // Snapshot is only reloaded when the streamer is free to take it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          snap_reg <= '0;
        end else if (load_snap) begin
          snap_reg <= cnt_sum[gi];
        end
      end
    end
  endgenerate

  // FSM state, stream pointer, sticky overrun flag and window-done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= '0;
      overrun_reg  <= 1'b0;
      win_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      overrun_reg  <= overrun_next;
      win_done_reg <= win_end;
    end
  end

  // Next-state and stream outputs; a window end coinciding with the final
  // accepted transfer reloads immediately instead of counting as an overrun.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    overrun_next = overrun_reg;
    load_snap    = 1'b0;
    rate_valid   = 1'b0;
    rate_ch      = '0;
    rate_val     = '0;
    rate_last    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (win_end) begin
          load_snap  = 1'b1;
          ptr_next   = '0;
          state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        rate_valid = 1'b1;
        rate_ch    = ptr_reg;
        rate_val   = snap_val[ptr_reg];
        rate_last  = (ptr_reg == PTR_LAST);
        if (win_end && rate_ready && (ptr_reg == PTR_LAST)) begin
          load_snap = 1'b1;
          ptr_next  = '0;
        end else begin
          if (win_end) begin
            overrun_next = 1'b1;
          end
          if (rate_ready) begin
            if (ptr_reg == PTR_LAST) begin
              ptr_next   = '0;
              state_next = S_IDLE;
            end else begin
              ptr_next = ptr_reg + PTR_W'(1);
            end
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        ptr_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder: table-driven windows plus hand-written
// handshake, overrun, reload and reset sequences; transfers checked against
// a scoreboard queue filled when each window's stimulus is driven.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] spike_in = 8'h00;
  logic       rate_ready = 1'b0;

  logic       rate_valid, rate_last, win_done, overrun;
  logic [2:0] rate_ch;
  logic [7:0] rate_val;

  logic       rate_valid4, rate_last4, win_done4, overrun4;
  logic [2:0] rate_ch4;
  logic [3:0] rate_val4;

  spike_rate_decoder #(.N_CH(8), .CNT_W(8), .WIN_LEN(16)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .rate_valid(rate_valid), .rate_ready(rate_ready), .rate_ch(rate_ch),
    .rate_val(rate_val), .rate_last(rate_last), .win_done(win_done), .overrun(overrun)
  );

  // Narrow-counter copy driven in lockstep to observe saturation at 15.
  spike_rate_decoder #(.N_CH(8), .CNT_W(4), .WIN_LEN(16)) dut4 (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .rate_valid(rate_valid4), .rate_ready(rate_ready), .rate_ch(rate_ch4),
    .rate_val(rate_val4), .rate_last(rate_last4), .win_done(win_done4), .overrun(overrun4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pat;
    int         first;
    int         n;
    bit         toggle;
    int         exp8;
    int         exp4;
  } vec_t;

  typedef struct {
    int ch;
    int val8;
    int val4;
    bit last;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   tests = 0;
  int   failed = 0;
  int   win_seen = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] pat, input int exp8, input int exp4);
    exp_t e;
    for (int c = 0; c < 8; c++) begin
      e.ch   = c;
      e.val8 = pat[c] ? exp8 : 0;
      e.val4 = pat[c] ? exp4 : 0;
      e.last = (c == 7);
      sb.push_back(e);
    end
  endtask

  // Drives one full window of 16 enabled cycles; spikes present on enabled
  // cycles first..first+n-1. With toggle, a disabled cycle precedes each
  // enabled one, spikes still applied so gating is exercised.
  task automatic run_window(input logic [7:0] pat, input int first, input int n,
                            input bit toggle, input int exp8, input int exp4,
                            input bit rdy, input bit push);
    int base;
    base = win_seen;
    rate_ready = rdy;
    if (push) push_exp(pat, exp8, exp4);
    for (int e = 0; e < 16; e++) begin
      if (e == 1) base = win_seen;
      if (e == 15) chk("no_early_window_end", win_seen, base);
      if (toggle) begin
        en = 1'b0;
        spike_in = pat;
        tick();
      end
      en = 1'b1;
      spike_in = (e >= first && e < first + n) ? pat : 8'h00;
      tick();
    end
    en = 1'b0;
    spike_in = 8'h00;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    rate_ready = 1'b1;
    while (sb.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    chk({name, "_all_delivered"}, sb.size(), 0);
    @(negedge clk);
    chk({name, "_idle_after"}, rate_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    spike_in = 8'h00;
    rate_ready = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: count win_done pulses and compare every accepted transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (win_done) win_seen++;
      if (rate_valid && rate_ready) begin
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_xfer: got ch %0d val %0d expected no transfer", rate_ch, rate_val);
        end else begin
          e = sb.pop_front();
          chk("xfer_ch", rate_ch, e.ch);
          chk("xfer_val", rate_val, e.val8);
          chk("xfer_last", rate_last, e.last);
          chk("xfer_val_sat4", rate_val4, e.val4);
          $display("[TB] xfer ch=%0d val=%0d val4=%0d last=%0d", rate_ch, rate_val, rate_val4, rate_last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    vecs[0] = '{8'h01, 0, 16, 1'b0, 16, 15};
    vecs[1] = '{8'h08, 0, 16, 1'b0, 16, 15};
    vecs[2] = '{8'h08, 0, 5, 1'b0, 5, 5};
    vecs[3] = '{8'hFF, 0, 16, 1'b1, 16, 15};
    vecs[4] = '{8'hA5, 4, 3, 1'b0, 3, 3};
    vecs[5] = '{8'h00, 0, 16, 1'b0, 0, 0};

    // Reset state.
    do_reset();
    @(negedge clk);
    chk("reset_valid", rate_valid, 0);
    chk("reset_ch", rate_ch, 0);
    chk("reset_val", rate_val, 0);
    chk("reset_last", rate_last, 0);
    chk("reset_win_done", win_done, 0);
    chk("reset_overrun", overrun, 0);

    // Table-driven windows with ready held high.
    for (int i = 0; i < 6; i++) begin
      base = win_seen;
      run_window(vecs[i].pat, vecs[i].first, vecs[i].n, vecs[i].toggle,
                 vecs[i].exp8, vecs[i].exp4, 1'b1, 1'b1);
      drain("vec");
      chk("vec_win_done_once", win_seen, base + 1);
      chk("vec_overrun", overrun, 0);
    end

    // Backpressure: ready low for 5 cycles, outputs held on ch0.
    base = win_seen;
    run_window(8'h01, 0, 16, 1'b0, 16, 15, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", rate_valid, 1);
      chk("hold_ch", rate_ch, 0);
      chk("hold_val", rate_val, 16);
    end
    drain("hold");
    chk("hold_win_done", win_seen, base + 1);

    // Overrun: a second window ends while the first snapshot is stalled.
    base = win_seen;
    run_window(8'h01, 0, 16, 1'b0, 16, 15, 1'b0, 1'b1);
    run_window(8'hFF, 0, 7, 1'b0, 7, 7, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", rate_valid, 1);
    chk("ovr_ch", rate_ch, 0);
    chk("ovr_val_first_window", rate_val, 16);
    drain("ovr");
    chk("ovr_win_done_twice", win_seen, base + 2);
    chk("ovr_sticky", overrun, 1);

    // Final transfer accepted on the same edge as the next window end.
    do_reset();
    base = win_seen;
    run_window(8'h04, 0, 16, 1'b0, 16, 15, 1'b0, 1'b1);
    push_exp(8'h11, 16, 15);
    for (int i = 0; i < 16; i++) begin
      en = 1'b1;
      spike_in = 8'h11;
      rate_ready = (i >= 8);
      tick();
    end
    en = 1'b0;
    spike_in = 8'h00;
    @(negedge clk);
    chk("reload_no_overrun", overrun, 0);
    chk("reload_valid", rate_valid, 1);
    chk("reload_ch", rate_ch, 0);
    chk("reload_val", rate_val, 16);
    drain("reload");
    chk("reload_win_done", win_seen, base + 2);

    // Asynchronous reset mid-stream at ptr=3.
    run_window(8'hFF, 0, 16, 1'b0, 16, 15, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pre_ch", rate_ch, 3);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", rate_valid, 0);
    chk("rst_async_ch", rate_ch, 0);
    chk("rst_async_val", rate_val, 0);
    chk("rst_async_last", rate_last, 0);
    chk("rst_async_overrun", overrun, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rate_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_release_idle", rate_valid, 0);
    end
    // Spike only on the window-end cycle lands in that window, not the next.
    base = win_seen;
    run_window(8'h81, 15, 1, 1'b0, 1, 1, 1'b1, 1'b1);
    run_window(8'h81, 0, 0, 1'b0, 0, 0, 1'b1, 1'b1);
    drain("rst");
    chk("rst_win_done", win_seen, base + 2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
